// File: rtl/ifft_pkg.sv
// ---------------------------------------------------------------------------
// ifft_pkg
//   Shared constants for the 8-point sequential radix-2 inverse FFT:
//   Q4.14 twiddle magnitudes, FSM state encodings and the 3-bit
//   bit-reverse table used to load the work RAM in DIT order.
// ---------------------------------------------------------------------------
package ifft_pkg;

  // Twiddles are Q4.14: 1.0 = 2^14, cos(pi/4) rounded = 11585.
  localparam int                 TW_FRAC = 14;
  localparam logic signed [17:0] TW_ONE  = 18'sd16384;
  localparam logic signed [17:0] TW_R2   = 18'sd11585;

  // FSM encodings. LOAD is the single cycle that copies the finished RAM
  // into the saturating output register.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // RAM slot j receives bin BITREV_TBL[j]: order 0,4,2,6,1,5,3,7.
  localparam logic [23:0] BITREV_TBL = {3'd7, 3'd3, 3'd5, 3'd1,
                                        3'd6, 3'd2, 3'd4, 3'd0};

  function automatic logic [2:0] bitrev3(input logic [2:0] idx);
    return BITREV_TBL[3*idx +: 3];
  endfunction

endpackage

// File: rtl/ifft_bfly_scaled.sv
// ---------------------------------------------------------------------------
// ifft_bfly_scaled
//   Combinational radix-2 DIT butterfly with 1/2 scaling.
//     t  = b * w          full-precision complex product, then >>> TW_FRAC
//     a' = (a + t) >>> 1
//     b' = (a - t) >>> 1  (all shifts truncate toward -inf)
// Ports
//   a_re_i/a_im_i, b_re_i/b_im_i   operands, signed DW bits
//   w_re_i/w_im_i                  twiddle, signed TW bits, Q4.14
//   ap_re_o/ap_im_o, bp_re_o/bp_im_o results, signed DW bits
// ---------------------------------------------------------------------------
module ifft_bfly_scaled
  import ifft_pkg::*;
#(
  parameter int DW = 20,
  parameter int TW = 18
) (
  input  logic signed [DW-1:0] a_re_i,
  input  logic signed [DW-1:0] a_im_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  input  logic signed [TW-1:0] w_re_i,
  input  logic signed [TW-1:0] w_im_i,
  output logic signed [DW-1:0] ap_re_o,
  output logic signed [DW-1:0] ap_im_o,
  output logic signed [DW-1:0] bp_re_o,
  output logic signed [DW-1:0] bp_im_o
);

  // One guard bit over the product width covers the complex add.
  localparam int PW = DW + TW + 1;

  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [PW-1:0] t_re, t_im;
  logic signed [PW-1:0] sum_re, sum_im, dif_re, dif_im;

  always_comb begin
    prod_re = PW'(b_re_i) * PW'(w_re_i) - PW'(b_im_i) * PW'(w_im_i);
    prod_im = PW'(b_re_i) * PW'(w_im_i) + PW'(b_im_i) * PW'(w_re_i);
    t_re    = prod_re >>> TW_FRAC;
    t_im    = prod_im >>> TW_FRAC;
    sum_re  = PW'(a_re_i) + t_re;
    sum_im  = PW'(a_im_i) + t_im;
    dif_re  = PW'(a_re_i) - t_re;
    dif_im  = PW'(a_im_i) - t_im;
    // The 1/2 scaling per stage keeps every stage result inside DW bits.
    ap_re_o = DW'(sum_re >>> 1);
    ap_im_o = DW'(sum_im >>> 1);
    bp_re_o = DW'(dif_re >>> 1);
    bp_im_o = DW'(dif_im >>> 1);
  end

endmodule

// File: rtl/ifft8_radix2_seq.sv
// ---------------------------------------------------------------------------
// ifft8_radix2_seq
//   8-point inverse FFT, one radix-2 DIT butterfly per clock
//   (3 stages x 4 butterflies), 1/2 scaling per stage, 1/8 overall.
//   One transform in flight; result held on out_re/out_im until accepted.
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready only while idle
//   in_re/in_im          8 bins, bin k at [k*IW +: IW], signed
//   out_valid/out_ready  output handshake; out_valid held until accepted
//   out_re/out_im        8 samples, sample n at [n*OW +: OW], saturated
//   busy                 high from accept until out_valid rises
// ---------------------------------------------------------------------------
module ifft8_radix2_seq
  import ifft_pkg::*;
#(
  parameter int IW = 19,
  parameter int OW = 19,
  parameter int TW = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*IW-1:0] in_re,
  input  logic [8*IW-1:0] in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*OW-1:0] out_re,
  output logic [8*OW-1:0] out_im,
  output logic            busy
);

  localparam int DW = IW + 1;

  localparam logic signed [TW-1:0] W_ONE = TW'(TW_ONE);
  localparam logic signed [TW-1:0] W_R2  = TW'(TW_R2);

  localparam logic signed [DW-1:0] SAT_MAX = DW'((64'sd1 <<< (OW-1)) - 64'sd1);
  localparam logic signed [DW-1:0] SAT_MIN = DW'(-(64'sd1 <<< (OW-1)));

  logic [1:0] state_q, state_d;
  logic [1:0] bf_q, bf_d;
  logic [1:0] stage_q, stage_d;
  logic       accept;

  logic signed [DW-1:0] ram_re_q [8];
  logic signed [DW-1:0] ram_im_q [8];
  logic [8*OW-1:0]      out_re_q, out_im_q;

  logic [2:0]           a_idx, b_idx;
  logic [1:0]           tw_k;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [DW-1:0] ap_re, ap_im, bp_re, bp_im;

  function automatic logic [OW-1:0] sat(input logic signed [DW-1:0] v);
    if (v > SAT_MAX)      return OW'(SAT_MAX);
    else if (v < SAT_MIN) return OW'(SAT_MIN);
    else                  return OW'(v);
  endfunction

  assign accept    = in_valid && (state_q == ST_IDLE);
  // Gated by rst so upstream never sees ready while the block is held.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC) || (state_q == ST_LOAD);
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

  // Butterfly addressing for stage s, span 2^s:
  //   a = (bf >> s) * 2^(s+1) + (bf mod 2^s), b = a + 2^s,
  //   twiddle k = (bf mod 2^s) * (4 >> s).
  always_comb begin
    a_idx = 3'd0;
    b_idx = 3'd0;
    tw_k  = 2'd0;
    case (stage_q)
      2'd0: begin
        a_idx = {bf_q, 1'b0};
        b_idx = {bf_q, 1'b1};
        tw_k  = 2'd0;
      end
      2'd1: begin
        a_idx = {bf_q[1], 1'b0, bf_q[0]};
        b_idx = {bf_q[1], 1'b1, bf_q[0]};
        tw_k  = {bf_q[0], 1'b0};
      end
      default: begin
        a_idx = {1'b0, bf_q};
        b_idx = {1'b1, bf_q};
        tw_k  = bf_q;
      end
    endcase
  end

  // Inverse-transform twiddle ROM: W^-k = e^{+j*2*pi*k/8}.
  always_comb begin
    w_re = W_ONE;
    w_im = '0;
    case (tw_k)
      2'd0: begin w_re = W_ONE; w_im = '0;    end
      2'd1: begin w_re = W_R2;  w_im = W_R2;  end
      2'd2: begin w_re = '0;    w_im = W_ONE; end
      default: begin w_re = -W_R2; w_im = W_R2; end
    endcase
  end

  ifft_bfly_scaled #(
    .DW (DW),
    .TW (TW)
  ) u_bfly (
    .a_re_i  (ram_re_q[a_idx]),
    .a_im_i  (ram_im_q[a_idx]),
    .b_re_i  (ram_re_q[b_idx]),
    .b_im_i  (ram_im_q[b_idx]),
    .w_re_i  (w_re),
    .w_im_i  (w_im),
    .ap_re_o (ap_re),
    .ap_im_o (ap_im),
    .bp_re_o (bp_re),
    .bp_im_o (bp_im)
  );

  always_comb begin
    state_d = state_q;
    bf_d    = bf_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CALC;
          bf_d    = 2'd0;
          stage_d = 2'd0;
        end
      end
      ST_CALC: begin
        bf_d = bf_q + 2'd1;
        if (bf_q == 2'd3) begin
          if (stage_q == 2'd2) begin
            stage_d = 2'd0;
            state_d = ST_LOAD;
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end
      end
      ST_LOAD: state_d = ST_DONE;
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bf_q    <= 2'd0;
      stage_q <= 2'd0;
    end else begin
      state_q <= state_d;
      bf_q    <= bf_d;
      stage_q <= stage_d;
    end
  end

  // Work RAM: loaded in bit-reversed order on accept, updated in place by
  // one butterfly per CALC cycle. Contents are don't-care outside a transform.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < 8; j++) begin
        ram_re_q[j] <= DW'($signed(in_re[bitrev3(3'(j))*IW +: IW]));
        ram_im_q[j] <= DW'($signed(in_im[bitrev3(3'(j))*IW +: IW]));
      end
    end else if (state_q == ST_CALC) begin
      ram_re_q[a_idx] <= ap_re;
      ram_im_q[a_idx] <= ap_im;
      ram_re_q[b_idx] <= bp_re;
      ram_im_q[b_idx] <= bp_im;
    end
  end

  // Output register: DIT leaves samples in natural order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_re_q <= '0;
      out_im_q <= '0;
    end else if (state_q == ST_LOAD) begin
      for (int n = 0; n < 8; n++) begin
        out_re_q[n*OW +: OW] <= sat(ram_re_q[n]);
        out_im_q[n*OW +: OW] <= sat(ram_im_q[n]);
      end
    end
  end

endmodule

// File: tb/tb_ifft8_radix2_seq.sv
// ---------------------------------------------------------------------------
// tb_ifft8_radix2_seq
//   Self-checking bench for ifft8_radix2_seq. Expected samples come from a
//   real-valued inverse DFT (x[n] = 1/8 * sum X[k] e^{+j2pi kn/8}), or, for
//   the round trip, from the original time samples fed through a real
//   forward DFT.
// ---------------------------------------------------------------------------
module tb_ifft8_radix2_seq;

  localparam int IW = 19;
  localparam int OW = 19;
  localparam int OMAX = (1 << (OW-1)) - 1;
  localparam int OMIN = -(1 << (OW-1));
  localparam real PI = 3.14159265358979323846;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [8*IW-1:0] in_re;
  logic [8*IW-1:0] in_im;
  logic            out_valid;
  logic            out_ready;
  logic [8*OW-1:0] out_re;
  logic [8*OW-1:0] out_im;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  int b_re [8];
  int b_im [8];
  int e_re [8];
  int e_im [8];

  ifft8_radix2_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    n_cmp++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd(input real v);
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  function automatic int clamp(input int v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  function automatic int smp_re(input int n);
    logic signed [OW-1:0] v;
    v = out_re[n*OW +: OW];
    return int'(v);
  endfunction

  function automatic int smp_im(input int n);
    logic signed [OW-1:0] v;
    v = out_im[n*OW +: OW];
    return int'(v);
  endfunction

  // Reference inverse DFT with 1/8 scaling, rounded and saturated.
  task automatic ref_idft();
    for (int n = 0; n < 8; n++) begin
      real sr, si, ang;
      sr = 0.0;
      si = 0.0;
      for (int k = 0; k < 8; k++) begin
        ang = 2.0 * PI * real'(k * n) / 8.0;
        sr += real'(b_re[k]) * $cos(ang) - real'(b_im[k]) * $sin(ang);
        si += real'(b_re[k]) * $sin(ang) + real'(b_im[k]) * $cos(ang);
      end
      e_re[n] = clamp(rnd(sr / 8.0));
      e_im[n] = clamp(rnd(si / 8.0));
    end
  endtask

  task automatic pack_bins();
    for (int k = 0; k < 8; k++) begin
      in_re[k*IW +: IW] = b_re[k][IW-1:0];
      in_im[k*IW +: IW] = b_im[k][IW-1:0];
    end
  endtask

  task automatic rand_bins();
    for (int k = 0; k < 8; k++) begin
      b_re[k] = int'($urandom_range(0, 131071)) - 65536;
      b_im[k] = int'($urandom_range(0, 131071)) - 65536;
    end
  endtask

  task automatic check_outputs(input string tag, input int tol);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("%s.re%0d", tag, n), smp_re(n), e_re[n], tol);
      check($sformatf("%s.im%0d", tag, n), smp_im(n), e_im[n], tol);
    end
  endtask

  // Waits for ready, presents b_re/b_im, checks latency and samples.
  // Leaves the block in DONE with out_ready low.
  task automatic run_xform(input string tag, input int tol);
    int cyc;
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".in_ready"}, int'(in_ready), 1, 0);
    pack_bins();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, ".busy"}, int'(busy), 1, 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ".latency"}, cyc, 13, 0);
    check_outputs(tag, tol);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".vld_after_hs"}, int'(out_valid), 0, 0);
    check({tag, ".rdy_after_hs"}, int'(in_ready), 1, 0);
  endtask

  initial begin
    int tries;
    int seen;
    int x_re [8];
    int x_im [8];
    logic ok;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_re     = '0;
    in_im     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", int'(in_ready), 0, 0);
    check("rst.out_valid", int'(out_valid), 0, 0);
    check("rst.busy", int'(busy), 0, 0);
    check("rst.out_re0", smp_re(0), 0, 0);
    check("rst.out_im7", smp_im(7), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel.in_ready", int'(in_ready), 1, 0);

    // Flat spectrum -> impulse at n=0
    for (int k = 0; k < 8; k++) begin b_re[k] = 8192; b_im[k] = 0; end
    ref_idft();
    run_xform("flat", 0);
    drain("flat");

    // DC bin only -> constant
    for (int k = 0; k < 8; k++) begin b_re[k] = 0; b_im[k] = 0; end
    b_re[0] = 8000;
    ref_idft();
    run_xform("dc", 0);
    drain("dc");

    // Bin 1 only -> rotating phasor
    for (int k = 0; k < 8; k++) begin b_re[k] = 0; b_im[k] = 0; end
    b_re[1] = 8192;
    ref_idft();
    run_xform("bin1", 1);
    drain("bin1");

    // Backpressure with ignored input pulses
    rand_bins();
    ref_idft();
    run_xform("bp", 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_re    = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_im    = {$urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check($sformatf("bp.vld%0d", i), int'(out_valid), 1, 0);
      check($sformatf("bp.rdy%0d", i), int'(in_ready), 0, 0);
      check($sformatf("bp.busy%0d", i), int'(busy), 0, 0);
      check_outputs($sformatf("bp.c%0d", i), 3);
    end
    in_valid = 1'b0;
    drain("bp");

    // Reset in the middle of CALC
    rand_bins();
    pack_bins();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort.busy_pre", int'(busy), 1, 0);
    rst = 1'b1;
    #1;
    check("abort.busy", int'(busy), 0, 0);
    check("abort.out_valid", int'(out_valid), 0, 0);
    check("abort.in_ready", int'(in_ready), 0, 0);
    check("abort.out_re0", smp_re(0), 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("abort.no_valid", seen, 0, 0);
    rand_bins();
    ref_idft();
    run_xform("post_abort", 3);
    drain("post_abort");

    // Random spectra against the reference inverse DFT
    for (int t = 0; t < 4; t++) begin
      rand_bins();
      ref_idft();
      run_xform($sformatf("rnd%0d", t), 3);
      drain($sformatf("rnd%0d", t));
    end

    // Round trip: time samples -> forward DFT -> DUT -> original samples
    for (int t = 0; t < 4; t++) begin
      tries = 0;
      ok = 1'b0;
      while (!ok && tries < 20) begin
        tries++;
        for (int n = 0; n < 8; n++) begin
          x_re[n] = int'($urandom_range(0, 131071)) - 65536;
          x_im[n] = int'($urandom_range(0, 131071)) - 65536;
        end
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
          real sr, si, ang;
          sr = 0.0;
          si = 0.0;
          for (int n = 0; n < 8; n++) begin
            ang = 2.0 * PI * real'(k * n) / 8.0;
            sr += real'(x_re[n]) * $cos(ang) + real'(x_im[n]) * $sin(ang);
            si += real'(x_im[n]) * $cos(ang) - real'(x_re[n]) * $sin(ang);
          end
          b_re[k] = rnd(sr);
          b_im[k] = rnd(si);
          if (b_re[k] > OMAX || b_re[k] < OMIN || b_im[k] > OMAX || b_im[k] < OMIN)
            ok = 1'b0;
        end
      end
      for (int n = 0; n < 8; n++) begin
        e_re[n] = x_re[n];
        e_im[n] = x_im[n];
      end
      run_xform($sformatf("rt%0d", t), 3);
      drain($sformatf("rt%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
